board_io_ctrl: RTL and testbench

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

---
 rtl/board_io_ctrl.sv | 176 +++++++++++++++++
 tb/tb_board_io_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// Board I/O controller: switch-loaded parameter bank, CONFIG/RUN sequencing,
// CPU clock-enable generation and paged, freezable result display.
module board_io_ctrl #(
    parameter int DATA_W     = 16,
    parameter int N_PARAMS   = 4,
    parameter int N_RES      = 4,
    parameter int RES_W      = 32,
    parameter int CE_DIV     = 4,
    parameter int PAGE_TICKS = 100000000
) (
    input  logic                                              in_clk,
    input  logic                                              in_rst,
    input  logic [DATA_W-1:0]                                 in_data,
    input  logic [(N_PARAMS > 1 ? $clog2(N_PARAMS) : 1)-1:0]  in_load_sel,
    input  logic                                              in_load,
    input  logic                                              in_page_btn,
    input  logic                                              in_auto,
    input  logic                                              in_freeze,
    input  logic [N_RES*RES_W-1:0]                            in_results,
    output logic [N_PARAMS*DATA_W-1:0]                        out_params,
    output logic [N_PARAMS-1:0]                               out_param_valid,
    output logic                                              out_run,
    output logic                                              out_cpu_ce,
    output logic [(N_RES > 1 ? $clog2(N_RES) : 1)-1:0]        out_page,
    output logic [RES_W-1:0]                                  out_disp_data
);

    localparam int SEL_W  = (N_PARAMS > 1) ? $clog2(N_PARAMS) : 1;
    localparam int PAGE_W = (N_RES > 1) ? $clog2(N_RES) : 1;
    localparam int CE_W   = $clog2(CE_DIV);
    localparam int TICK_W = $clog2(PAGE_TICKS);

    localparam logic [SEL_W:0]    SEL_LIM   = (SEL_W+1)'(N_PARAMS);
    localparam logic [CE_W-1:0]   CE_MAX    = CE_W'(CE_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(PAGE_TICKS - 1);
    localparam logic [PAGE_W-1:0] PAGE_MAX  = PAGE_W'(N_RES - 1);

    typedef enum logic {
        ST_CONFIG = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                load_prev_p0;
    logic                page_prev_p0;
    logic                load_evt;
    logic                page_evt;
    logic                sel_ok;

    logic [DATA_W-1:0]   params_p0 [N_PARAMS];
    logic [N_PARAMS-1:0] param_vld_p0;

    logic [CE_W-1:0]     ce_cnt_q;
    logic [TICK_W-1:0]   tick_cnt_q;
    logic [PAGE_W-1:0]   page_q;
    logic [PAGE_W-1:0]   page_next;

    logic [RES_W-1:0]    res_sel;
    logic [RES_W-1:0]    disp_data_p1;

    // ---- Stage 0: button edge detection against the registered sample
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            load_prev_p0 <= 1'b0;
            page_prev_p0 <= 1'b0;
        end else begin
            load_prev_p0 <= in_load;
            page_prev_p0 <= in_page_btn;
        end
    end

    assign load_evt = in_load & ~load_prev_p0;
    assign page_evt = in_page_btn & ~page_prev_p0;
    assign sel_ok   = ({1'b0, in_load_sel} < SEL_LIM);

    // ---- Control FSM: RUN is left only through reset
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= ST_CONFIG;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CONFIG: if (&param_vld_p0) state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_CONFIG;
        endcase
    end

    assign out_run = (state_q == ST_RUN);

    // ---- Parameter bank: writable only while configuring
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < N_PARAMS; i++) begin
                params_p0[i] <= '0;
            end
            param_vld_p0 <= '0;
        end else if ((state_q == ST_CONFIG) && load_evt && sel_ok) begin
            for (int i = 0; i < N_PARAMS; i++) begin
                if (in_load_sel == SEL_W'(i)) begin
                    params_p0[i]    <= in_data;
                    param_vld_p0[i] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_PARAMS; g++) begin : g_pack_params
        assign out_params[g*DATA_W +: DATA_W] = params_p0[g];
    end

    assign out_param_valid = param_vld_p0;

    // ---- CPU clock enable: counter parked at zero outside RUN
    always_ff @(posedge in_clk) begin
        if (in_rst || (state_q != ST_RUN)) begin
            ce_cnt_q <= '0;
        end else if (ce_cnt_q == CE_MAX) begin
            ce_cnt_q <= '0;
        end else begin
            ce_cnt_q <= ce_cnt_q + CE_W'(1);
        end
    end

    assign out_cpu_ce = (state_q == ST_RUN) && (ce_cnt_q == CE_MAX);

    // ---- Page selection: manual button or periodic auto-advance
    assign page_next = (page_q == PAGE_MAX) ? '0 : page_q + PAGE_W'(1);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            page_q     <= '0;
            tick_cnt_q <= '0;
        end else if (!in_auto) begin
            tick_cnt_q <= '0;
            if (page_evt) begin
                page_q <= page_next;
            end
        end else if (tick_cnt_q == TICK_MAX) begin
            tick_cnt_q <= '0;
            page_q     <= page_next;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    assign out_page = page_q;

    always_comb begin
        res_sel = '0;
        for (int k = 0; k < N_RES; k++) begin
            if (page_q == PAGE_W'(k)) begin
                res_sel = in_results[k*RES_W +: RES_W];
            end
        end
    end

    // ---- Stage 1: display register, frozen snapshot while in_freeze is high
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            disp_data_p1 <= '0;
        end else if (!in_freeze) begin
            disp_data_p1 <= res_sel;
        end
    end

    assign out_disp_data = disp_data_p1;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl: configuration table, CE timing, paging,
// freeze behaviour, reset priority and out-of-range load select.
module tb_board_io_ctrl;

    logic         clk;
    logic         rst;
    logic [15:0]  in_data;
    logic [1:0]   in_load_sel;
    logic         in_load;
    logic         in_page_btn;
    logic         in_auto;
    logic         in_freeze;
    logic [127:0] in_results;
    logic [63:0]  out_params;
    logic [3:0]   out_param_valid;
    logic         out_run;
    logic         out_cpu_ce;
    logic [1:0]   out_page;
    logic [31:0]  out_disp_data;

    // Second instance with five parameters, so a select of 5 is representable
    logic [15:0]  b_data;
    logic [2:0]   b_sel;
    logic         b_load;
    logic [79:0]  b_params;
    logic [4:0]   b_vld;
    logic         b_run;
    logic         b_ce;
    logic [1:0]   b_page;
    logic [31:0]  b_disp;

    int total;
    int bad;

    board_io_ctrl #(
        .DATA_W(16), .N_PARAMS(4), .N_RES(4), .RES_W(32), .CE_DIV(4), .PAGE_TICKS(8)
    ) dut (
        .in_clk(clk), .in_rst(rst), .in_data(in_data), .in_load_sel(in_load_sel),
        .in_load(in_load), .in_page_btn(in_page_btn), .in_auto(in_auto),
        .in_freeze(in_freeze), .in_results(in_results), .out_params(out_params),
        .out_param_valid(out_param_valid), .out_run(out_run), .out_cpu_ce(out_cpu_ce),
        .out_page(out_page), .out_disp_data(out_disp_data)
    );

    board_io_ctrl #(
        .DATA_W(16), .N_PARAMS(5), .N_RES(4), .RES_W(32), .CE_DIV(4), .PAGE_TICKS(8)
    ) dut_b (
        .in_clk(clk), .in_rst(rst), .in_data(b_data), .in_load_sel(b_sel),
        .in_load(b_load), .in_page_btn(in_page_btn), .in_auto(in_auto),
        .in_freeze(in_freeze), .in_results(in_results), .out_params(b_params),
        .out_param_valid(b_vld), .out_run(b_run), .out_cpu_ce(b_ce),
        .out_page(b_page), .out_disp_data(b_disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [63:0] exp_params;
        logic [3:0]  exp_vld;
        logic        exp_run;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [1:0] sel, input logic [15:0] data);
        in_load_sel = sel;
        in_data     = data;
        in_load     = 1'b1;
        step();
        in_load     = 1'b0;
        step();
    endtask

    task automatic press_page();
        in_page_btn = 1'b1;
        step();
        in_page_btn = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{1'b1, 2'd0, 16'h0064, 64'h0000_0000_0000_0064, 4'b0001, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 16'h0064, 64'h0000_0000_0000_0064, 4'b0001, 1'b0};
        vecs[2] = '{1'b1, 2'd1, 16'h0003, 64'h0000_0000_0003_0064, 4'b0011, 1'b0};
        vecs[3] = '{1'b1, 2'd1, 16'hFFFF, 64'h0000_0000_0003_0064, 4'b0011, 1'b0};
        vecs[4] = '{1'b0, 2'd2, 16'h0001, 64'h0000_0000_0003_0064, 4'b0011, 1'b0};
        vecs[5] = '{1'b1, 2'd2, 16'h0001, 64'h0000_0001_0003_0064, 4'b0111, 1'b0};
        vecs[6] = '{1'b0, 2'd3, 16'h0002, 64'h0000_0001_0003_0064, 4'b0111, 1'b0};
        vecs[7] = '{1'b1, 2'd3, 16'h0002, 64'h0002_0001_0003_0064, 4'b1111, 1'b0};
        vecs[8] = '{1'b0, 2'd0, 16'hFFFF, 64'h0002_0001_0003_0064, 4'b1111, 1'b1};
        vecs[9] = '{1'b1, 2'd0, 16'hFFFF, 64'h0002_0001_0003_0064, 4'b1111, 1'b1};

        rst         = 1'b1;
        in_data     = '0;
        in_load_sel = '0;
        in_load     = 1'b0;
        in_page_btn = 1'b0;
        in_auto     = 1'b0;
        in_freeze   = 1'b0;
        in_results  = '0;
        b_data      = '0;
        b_sel       = '0;
        b_load      = 1'b0;
        step();
        step();

        chk("rst_params", out_params, 0);
        chk("rst_valid", out_param_valid, 0);
        chk("rst_run", out_run, 0);
        chk("rst_ce", out_cpu_ce, 0);
        chk("rst_page", out_page, 0);
        chk("rst_disp", out_disp_data, 0);

        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_load     = vecs[i].load;
            in_load_sel = vecs[i].sel;
            in_data     = vecs[i].data;
            step();
            chk($sformatf("vec%0d_params", i), out_params, vecs[i].exp_params);
            chk($sformatf("vec%0d_valid", i), out_param_valid, vecs[i].exp_vld);
            chk($sformatf("vec%0d_run", i), out_run, vecs[i].exp_run);
            if (!vecs[i].exp_run) chk($sformatf("vec%0d_ce_config", i), out_cpu_ce, 0);
        end

        // Locked parameters: load held high for ten cycles in RUN
        in_load = 1'b0;
        step();
        in_load     = 1'b1;
        in_load_sel = 2'd0;
        in_data     = 16'hFFFF;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("run_lock_c%0d", c), out_params[15:0], 16'h0064);
        end
        in_load = 1'b0;

        // Fresh configuration, then count CE pulses from the first RUN cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        do_load(2'd0, 16'h0064);
        do_load(2'd1, 16'h0003);
        do_load(2'd2, 16'h0001);
        do_load(2'd3, 16'h0002);
        chk("ce_run_entry", out_run, 1);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) step();
            chk($sformatf("ce_cycle%0d", c), out_cpu_ce, ((c % 4) == 0) ? 1 : 0);
        end

        // Manual paging, with a button held high for an extra cycle
        in_page_btn = 1'b1;
        step();
        chk("page_press1", out_page, 1);
        step();
        chk("page_hold", out_page, 1);
        in_page_btn = 1'b0;
        step();
        for (int p = 2; p <= 5; p++) begin
            press_page();
            chk($sformatf("page_press%0d", p), out_page, p % 4);
        end

        // Auto paging every 8 cycles, button activity ignored
        in_auto = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            if (c == 3) in_page_btn = 1'b1;
            if (c == 5) in_page_btn = 1'b0;
            step();
            chk($sformatf("auto_c%0d", c), out_page, (1 + c / 8) % 4);
        end
        in_auto = 1'b0;

        // Freeze: navigate to page 2 and snapshot channel 2
        in_results = {32'h33333333, 32'h12345678, 32'h11111111, 32'hC0C0C0C0};
        press_page();
        press_page();
        press_page();
        chk("frz_page2", out_page, 2);
        chk("frz_live", out_disp_data, 32'h12345678);
        in_freeze = 1'b1;
        in_results[64 +: 32] = 32'hDEADBEEF;
        step();
        chk("frz_hold1", out_disp_data, 32'h12345678);
        step();
        chk("frz_hold2", out_disp_data, 32'h12345678);
        in_freeze = 1'b0;
        step();
        chk("frz_release", out_disp_data, 32'hDEADBEEF);
        in_freeze = 1'b1;
        press_page();
        chk("frz_page_adv", out_page, 3);
        chk("frz_hold_adv", out_disp_data, 32'hDEADBEEF);
        in_freeze = 1'b0;
        step();
        chk("frz_release_ch3", out_disp_data, 32'h33333333);

        // Reset mid-RUN with a load and page press on the same edge
        rst         = 1'b1;
        in_load     = 1'b1;
        in_load_sel = 2'd0;
        in_data     = 16'h1234;
        in_page_btn = 1'b1;
        step();
        chk("mrst_params", out_params, 0);
        chk("mrst_valid", out_param_valid, 0);
        chk("mrst_run", out_run, 0);
        chk("mrst_ce", out_cpu_ce, 0);
        chk("mrst_page", out_page, 0);
        chk("mrst_disp", out_disp_data, 0);
        rst         = 1'b0;
        in_load     = 1'b0;
        in_page_btn = 1'b0;
        step();
        chk("mrst_after_params", out_params, 0);
        chk("mrst_after_run", out_run, 0);

        // Out-of-range selects on the five-parameter instance
        b_data = 16'hABCD;
        b_sel  = 3'd5;
        b_load = 1'b1;
        step();
        b_load = 1'b0;
        step();
        chk("oor_sel5_vld", b_vld, 0);
        chk("oor_sel5_params", b_params, 0);
        b_sel  = 3'd7;
        b_load = 1'b1;
        step();
        b_load = 1'b0;
        step();
        chk("oor_sel7_vld", b_vld, 0);
        b_sel  = 3'd4;
        b_load = 1'b1;
        step();
        b_load = 1'b0;
        step();
        chk("sel4_vld", b_vld, 5'b10000);
        chk("sel4_param", b_params[79:64], 16'hABCD);
        chk("sel4_run", b_run, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
